// File: rtl/vram_word_reader_if.sv
// Bus bundle for vram_word_reader: transfer control, RAM port B read side
// and the outgoing 16-bit word stream.
interface vram_word_reader_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 12
);
    logic                      start;
    logic [ADDR_WIDTH-1:0]     start_addr;
    logic [LEN_WIDTH-1:0]      word_count;
    logic                      abort;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0]     ram_q;
    logic [2*DATA_WIDTH-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic                      busy;
    logic                      done;

    // Reader side
    modport master (
        input  start, start_addr, word_count, abort, ram_q, out_ready,
        output ram_addr, out_data, out_valid, out_last, busy, done
    );

    // Environment side: requester, RAM and word consumer
    modport slave (
        output start, start_addr, word_count, abort, ram_q, out_ready,
        input  ram_addr, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/vram_word_reader.sv
// Reads byte pairs from the vector/work RAM read port and streams them out as
// little-endian words through a 2-entry buffer guarded by a fetch credit rule.
module vram_word_reader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    vram_word_reader_if.master   bus
);
    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                    rd_lo_q, rd_lo_d;
    logic                    rd_hi_q, rd_hi_d;
    logic                    rd_last_q, rd_last_d;
    logic                    cap_lo_q, cap_lo_d;
    logic                    cap_hi_q, cap_hi_d;
    logic                    cap_last_q, cap_last_d;
    logic [DATA_WIDTH-1:0]   lo_byte_q, lo_byte_d;
    logic [1:0]              inflight_q, inflight_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [WORD_WIDTH-1:0]   data0_q, data0_d;
    logic [WORD_WIDTH-1:0]   data1_q, data1_d;
    logic                    last0_q, last0_d;
    logic                    last1_q, last1_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    push_s;
    logic                    pop_s;
    logic [1:0]              wr_base_s;
    logic [1:0]              inflight_base_s;
    logic                    credit_ok_s;

    // Next-state logic: read issue sequencing, byte capture, buffer and completion
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        ram_addr_d  = ram_addr_q;
        rd_lo_d     = 1'b0;
        rd_hi_d     = 1'b0;
        rd_last_d   = 1'b0;
        cap_lo_d    = rd_lo_q;
        cap_hi_d    = rd_hi_q;
        cap_last_d  = rd_last_q;
        lo_byte_d   = lo_byte_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;

        // A word is pushed when its high byte is on ram_q; head pops on handshake.
        push_s          = cap_hi_q;
        pop_s           = out_valid_q & bus.out_ready;
        wr_base_s       = fifo_cnt_q - {1'b0, pop_s};
        fifo_cnt_d      = wr_base_s + {1'b0, push_s};
        inflight_base_s = inflight_q - {1'b0, push_s};
        inflight_d      = inflight_base_s;
        // Post-edge occupancy plus outstanding words must leave room for one more.
        credit_ok_s     = (({1'b0, fifo_cnt_d} + {1'b0, inflight_base_s}) < 3'd2);

        if (cap_lo_q) begin
            lo_byte_d = bus.ram_q;
        end else begin
            lo_byte_d = lo_byte_q;
        end

        if (pop_s) begin
            data0_d = data1_q;
            last0_d = last1_q;
        end else begin
            data0_d = data0_q;
            last0_d = last0_q;
        end

        if (push_s) begin
            if (wr_base_s == 2'd0) begin
                data0_d = {bus.ram_q, lo_byte_q};
                last0_d = cap_last_q;
            end else begin
                data1_d = {bus.ram_q, lo_byte_q};
                last1_d = cap_last_q;
            end
        end else begin
            data1_d = data1_q;
            last1_d = last1_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.word_count != LEN_WIDTH'(0)) begin
                        state_d     = S_RUN;
                        ptr_d       = bus.start_addr;
                        remaining_d = bus.word_count;
                        ram_addr_d  = bus.start_addr;
                        rd_lo_d     = 1'b1;
                        inflight_d  = inflight_base_s + 2'd1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (rd_lo_q) begin
                    // High byte always follows its low byte on the next cycle.
                    ram_addr_d  = ptr_q + ADDR_WIDTH'(1);
                    rd_hi_d     = 1'b1;
                    ptr_d       = ptr_q + ADDR_WIDTH'(2);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        rd_last_d = 1'b1;
                        state_d   = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (credit_ok_s) begin
                    ram_addr_d = ptr_q;
                    rd_lo_d    = 1'b1;
                    inflight_d = inflight_base_s + 2'd1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if ((fifo_cnt_d == 2'd0) && (inflight_base_s == 2'd0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards everything queued or outstanding, including a same-cycle start.
        if (bus.abort) begin
            state_d     = S_IDLE;
            ram_addr_d  = ram_addr_q;
            rd_lo_d     = 1'b0;
            rd_hi_d     = 1'b0;
            rd_last_d   = 1'b0;
            cap_lo_d    = 1'b0;
            cap_hi_d    = 1'b0;
            cap_last_d  = 1'b0;
            fifo_cnt_d  = 2'd0;
            inflight_d  = 2'd0;
            done_d      = 1'b0;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            busy_d      = (state_d != S_IDLE);
            out_valid_d = (fifo_cnt_d != 2'd0);
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= {ADDR_WIDTH{1'b0}};
            remaining_q <= {LEN_WIDTH{1'b0}};
            ram_addr_q  <= {ADDR_WIDTH{1'b0}};
            rd_lo_q     <= 1'b0;
            rd_hi_q     <= 1'b0;
            rd_last_q   <= 1'b0;
            cap_lo_q    <= 1'b0;
            cap_hi_q    <= 1'b0;
            cap_last_q  <= 1'b0;
            lo_byte_q   <= {DATA_WIDTH{1'b0}};
            inflight_q  <= 2'd0;
            fifo_cnt_q  <= 2'd0;
            data0_q     <= {WORD_WIDTH{1'b0}};
            data1_q     <= {WORD_WIDTH{1'b0}};
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            ram_addr_q  <= ram_addr_d;
            rd_lo_q     <= rd_lo_d;
            rd_hi_q     <= rd_hi_d;
            rd_last_q   <= rd_last_d;
            cap_lo_q    <= cap_lo_d;
            cap_hi_q    <= cap_hi_d;
            cap_last_q  <= cap_last_d;
            lo_byte_q   <= lo_byte_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.out_data  = data0_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = last0_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_vram_word_reader.sv
// Scoreboard bench for vram_word_reader: directed transfers push expected
// words; a negedge monitor pops and compares on every output handshake.
module tb_vram_word_reader;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int LW = 12;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clock;
    logic reset_n;
    vram_word_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    vram_word_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] mem [0:32767];
    exp_t       exp_q [$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         hs_cnt   = 0;
    bit         stall_v  = 1'b0;
    logic [15:0] held_data;
    logic        held_last;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM port B model: one-cycle registered read
    always @(posedge clock) bus.ram_q <= mem[bus.ram_addr];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: handshake scoreboard, stall stability and done pulse counting
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.done) done_cnt++;
            if (stall_v && bus.out_valid)
                check((bus.out_data == held_data) && (bus.out_last == held_last), "stall_hold",
                      {15'd0, bus.out_last, bus.out_data}, {15'd0, held_last, held_data});
            stall_v   = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            held_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", {16'd0, bus.out_data}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.out_data == e.data, "word_data", {16'd0, bus.out_data}, {16'd0, e.data});
                    check(bus.out_last == e.last, "word_last", {31'd0, bus.out_last}, {31'd0, e.last});
                end
            end
        end else begin
            stall_v = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic l);
        exp_t x;
        x.data = d;
        x.last = l;
        exp_q.push_back(x);
    endtask

    task automatic queue_stream(input logic [14:0] addr, input int count);
        logic [14:0] a;
        for (int i = 0; i < count; i++) begin
            a = addr + 15'(2 * i);
            push_exp({mem[a + 15'd1], mem[a]}, (i == count - 1));
        end
    endtask

    task automatic pulse_start(input logic [14:0] addr, input logic [11:0] count);
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.word_count = count;
        tick(1);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!bus.done && cyc < budget) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic expect_done(input string name, input int exp_cyc);
        int cyc;
        int d0;
        d0 = done_cnt;
        wait_done(200, cyc);
        check(cyc == exp_cyc, {name, "_done_latency"}, cyc, exp_cyc);
        tick(3);
        check(done_cnt == d0 + 1, {name, "_done_pulses"}, done_cnt - d0, 1);
        check(exp_q.size() == 0, {name, "_words_left"}, exp_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check({bus.ram_addr, bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done} == 35'd0,
              name, {bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data}, 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;
        int h0;
        bit seen;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = 15'd0;
        bus.word_count = 12'd0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h0100] = 8'h34;
        mem[15'h0101] = 8'h12;
        for (int i = 0; i < 16; i++) mem[15'h0200 + i] = 8'(i);
        for (int i = 0; i < 12; i++) mem[15'h0210 + i] = 8'(8'h40 + i);
        mem[15'h7FFE] = 8'hAA;
        mem[15'h7FFF] = 8'hBB;
        mem[15'h0000] = 8'hCC;
        mem[15'h0001] = 8'hDD;

        tick(3);
        check_zero("reset_state");
        reset_n = 1'b1;
        tick(1);

        // Single word: latency 3, done after handshake, busy window
        bus.out_ready = 1'b1;
        push_exp(16'h1234, 1'b1);
        pulse_start(15'h0100, 12'd1);
        check(bus.busy == 1'b1, "single_busy_rise", bus.busy, 1);
        tick(2);
        check(bus.out_valid == 1'b0, "single_not_early", bus.out_valid, 0);
        tick(1);
        check(bus.out_valid == 1'b1, "single_valid_at_3", bus.out_valid, 1);
        check(bus.out_data == 16'h1234, "single_data", bus.out_data, 16'h1234);
        check(bus.busy == 1'b1, "single_busy_hold", bus.busy, 1);
        tick(1);
        check(bus.done == 1'b1, "single_done", bus.done, 1);
        check(bus.busy == 1'b0, "single_busy_fall", bus.busy, 0);
        check(bus.out_valid == 1'b0, "single_valid_fall", bus.out_valid, 0);
        tick(1);
        check(bus.done == 1'b0, "single_done_width", bus.done, 0);

        // Streaming: 8 words, one per 2 cycles
        queue_stream(15'h0200, 8);
        pulse_start(15'h0200, 12'd8);
        expect_done("stream", 18);

        // Backpressure: random ready with a 10-cycle hold at 0
        queue_stream(15'h0210, 6);
        d0   = done_cnt;
        seen = 1'b0;
        pulse_start(15'h0210, 12'd6);
        for (int c = 0; c < 300 && !seen; c++) begin
            if (c >= 6 && c < 16) bus.out_ready = 1'b0;
            else                  bus.out_ready = 1'($urandom_range(0, 1));
            tick(1);
            if (bus.done) seen = 1'b1;
        end
        bus.out_ready = 1'b1;
        check(seen, "bp_done_seen", seen, 1);
        tick(3);
        check(done_cnt == d0 + 1, "bp_done_pulses", done_cnt - d0, 1);
        check(exp_q.size() == 0, "bp_words_left", exp_q.size(), 0);

        // Address wrap at the top of the RAM
        push_exp(16'hBBAA, 1'b0);
        push_exp(16'hDDCC, 1'b1);
        pulse_start(15'h7FFE, 12'd2);
        expect_done("wrap", 6);

        // Zero-length request
        d0 = done_cnt;
        pulse_start(15'h0100, 12'd0);
        check(bus.done == 1'b1, "zero_done", bus.done, 1);
        check(bus.busy == 1'b0, "zero_busy", bus.busy, 0);
        check(bus.out_valid == 1'b0, "zero_valid", bus.out_valid, 0);
        tick(1);
        check(bus.done == 1'b0, "zero_done_width", bus.done, 0);
        tick(2);
        check(done_cnt == d0 + 1, "zero_done_pulses", done_cnt - d0, 1);

        // Abort mid-transfer, with a simultaneous start that must be dropped
        queue_stream(15'h0200, 10);
        h0 = hs_cnt;
        pulse_start(15'h0200, 12'd10);
        cyc = 0;
        while (hs_cnt < h0 + 3 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check(hs_cnt >= h0 + 3, "abort_three_words", hs_cnt - h0, 3);
        bus.out_ready = 1'b0;
        tick(4);
        bus.abort      = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = 15'h0100;
        bus.word_count = 12'd1;
        tick(1);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check(bus.out_valid == 1'b0, "abort_valid", bus.out_valid, 0);
        check(bus.busy == 1'b0, "abort_busy", bus.busy, 0);
        check(bus.done == 1'b0, "abort_no_done", bus.done, 0);
        exp_q.delete();
        d0 = done_cnt;
        tick(6);
        check(done_cnt == d0, "abort_quiet_done", done_cnt - d0, 0);
        check({bus.busy, bus.out_valid} == 2'b00, "abort_start_dropped", {bus.busy, bus.out_valid}, 0);
        bus.out_ready = 1'b1;
        push_exp(16'h1234, 1'b1);
        pulse_start(15'h0100, 12'd1);
        expect_done("abort_restart", 4);

        // Reset mid-transfer
        bus.out_ready = 1'b0;
        queue_stream(15'h0200, 10);
        pulse_start(15'h0200, 12'd10);
        tick(5);
        reset_n = 1'b0;
        tick(1);
        check_zero("reset_mid");
        reset_n = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        tick(3);
        check((done_cnt == d0) && (bus.busy == 1'b0), "reset_quiet", {bus.busy, 8'(done_cnt - d0)}, 0);
        bus.out_ready = 1'b1;
        push_exp(16'hBBAA, 1'b0);
        push_exp(16'hDDCC, 1'b1);
        pulse_start(15'h7FFE, 12'd2);
        expect_done("reset_restart", 6);

        // Start while busy is ignored
        queue_stream(15'h0200, 4);
        d0 = done_cnt;
        pulse_start(15'h0200, 12'd4);
        tick(2);
        pulse_start(15'h7FFE, 12'd2);
        wait_done(200, cyc);
        check(cyc + 3 == 10, "busy_start_latency", cyc + 3, 10);
        tick(3);
        check(done_cnt == d0 + 1, "busy_start_pulses", done_cnt - d0, 1);
        check(exp_q.size() == 0, "busy_start_words_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
